// File: rtl/issue_int_scheduler_pkg.sv
// Shared sizing constants, grant record type and small helpers for the integer issue scheduler.
package issue_int_scheduler_pkg;

  localparam int ENTRY_NUM  = 32;
  localparam int IDX_W      = 5;
  localparam int DISP_W     = 4;
  localparam int REQ_THRESH = 4;
  localparam int CNT_W      = IDX_W + 1;

  typedef logic [ENTRY_NUM-1:0] emask_t;
  typedef logic [IDX_W-1:0]     eidx_t;

  typedef struct packed {
    logic  vld;
    eidx_t idx;
  } grant_t;

  function automatic emask_t grant_mask(grant_t g);
    emask_t m;
    m = '0;
    if (g.vld) m[g.idx] = 1'b1;
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] count_disp(logic [DISP_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int k = 0; k < DISP_W; k++) c = c + {{(CNT_W-1){1'b0}}, v[k]};
    return c;
  endfunction

endpackage

// File: rtl/issue_int_scheduler_if.sv
// Allocation, wakeup and grant bundle between the integer issue queue/front end and its scheduler.
interface issue_int_scheduler_if;
  import issue_int_scheduler_pkg::*;

  logic                    IsQuIntStop;
  logic                    IsQuIntFlash;
  logic                    IsQuIntReq;
  logic [DISP_W-1:0]       AllocReq;
  logic [DISP_W-1:0]       AllocMul;
  logic [DISP_W*IDX_W-1:0] AllocIdx;
  logic [DISP_W-1:0]       AllocAck;
  logic [ENTRY_NUM-1:0]    EntryReady;
  logic                    Alu1Valid;
  logic [IDX_W-1:0]        Alu1Idx;
  logic                    Alu2Valid;
  logic [IDX_W-1:0]        Alu2Idx;
  logic                    MulValid;
  logic [IDX_W-1:0]        MulIdx;
  logic [IDX_W:0]          FreeCnt;

  modport master (
    output IsQuIntStop, IsQuIntFlash, AllocReq, AllocMul, EntryReady,
    input  IsQuIntReq, AllocIdx, AllocAck, Alu1Valid, Alu1Idx, Alu2Valid, Alu2Idx,
           MulValid, MulIdx, FreeCnt
  );

  modport slave (
    input  IsQuIntStop, IsQuIntFlash, AllocReq, AllocMul, EntryReady,
    output IsQuIntReq, AllocIdx, AllocAck, Alu1Valid, Alu1Idx, Alu2Valid, Alu2Idx,
           MulValid, MulIdx, FreeCnt
  );

endinterface

// File: rtl/issue_int_scheduler_age_pick.sv
// Oldest-candidate picker. With ISQ_INT_AGE_SELECT_EN defined it uses the age matrix;
// otherwise it is a lowest-index priority encoder.
module isq_age_pick
  import issue_int_scheduler_pkg::*;
(
  input  emask_t                 cand_i,
`ifdef ISQ_INT_AGE_SELECT_EN
  input  emask_t [ENTRY_NUM-1:0] older_i,
`endif
  input  emask_t                 excl_i,
  output logic                   found_o,
  output eidx_t                  idx_o
);

  emask_t eff;
  assign eff = cand_i & ~excl_i;

  // Scan downward so the lowest index wins if more than one entry qualifies.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
`ifdef ISQ_INT_AGE_SELECT_EN
      if (eff[i] && ((older_i[i] & eff) == '0)) begin
`else
      if (eff[i]) begin
`endif
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/issue_int_scheduler.sv
// Integer issue-queue slot allocator and ALU/ALU/MUL select controller.
// Define ISQ_INT_AGE_SELECT_EN for oldest-first select; otherwise lowest index wins.
module issue_int_scheduler
  import issue_int_scheduler_pkg::*;
(
  input logic                  Clk,
  input logic                  Rest,
  issue_int_scheduler_if.slave isq
);

  emask_t           valid_q, valid_d;
  emask_t           ismul_q, ismul_d;
  grant_t           alu1_q, alu1_d, alu2_q, alu2_d, mul_q, mul_d;
  logic [CNT_W-1:0] freecnt_q, freecnt_d;
`ifdef ISQ_INT_AGE_SELECT_EN
  emask_t [ENTRY_NUM-1:0] older_q, older_d;
  emask_t                 age_row;
`endif

  emask_t                  issued, free_m, cand, alu_cand, mul_cand, pick_m, alloc_m;
  logic                    alloc_en;
  eidx_t [DISP_W-1:0]      slot_idx;
  logic [DISP_W-1:0]       slot_found, ack;
  logic                    a1_found, a2_found, m_found;
  eidx_t                   a1_idx, a2_idx, m_idx;
  grant_t                  alu1_pick, alu2_pick, mul_pick;

  assign isq.IsQuIntReq = (freecnt_q < CNT_W'(REQ_THRESH));
  assign alloc_en       = ~isq.IsQuIntReq & ~isq.IsQuIntStop & ~isq.IsQuIntFlash;

  // Entries whose grant is on the outputs are not reused until the following cycle.
  assign issued = grant_mask(alu1_q) | grant_mask(alu2_q) | grant_mask(mul_q);
  assign free_m = ~valid_q & ~issued;

  always_comb begin
    int n;
    n          = 0;
    slot_idx   = '0;
    slot_found = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (free_m[i]) begin
        for (int k = 0; k < DISP_W; k++) begin
          if (n == k) begin
            slot_idx[k]   = IDX_W'(i);
            slot_found[k] = 1'b1;
          end
        end
        n = n + 1;
      end
    end
  end

  assign ack          = isq.AllocReq & slot_found & {DISP_W{alloc_en}};
  assign isq.AllocAck = ack;
  assign isq.AllocIdx = slot_idx;

  always_comb begin
    alloc_m = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (ack[k]) alloc_m[slot_idx[k]] = 1'b1;
    end
  end

  assign cand     = valid_q & isq.EntryReady & ~issued;
  assign alu_cand = cand & ~ismul_q;
  assign mul_cand = cand & ismul_q;

  isq_age_pick u_pick_alu1 (
    .cand_i  (alu_cand),
`ifdef ISQ_INT_AGE_SELECT_EN
    .older_i (older_q),
`endif
    .excl_i  ('0),
    .found_o (a1_found),
    .idx_o   (a1_idx)
  );

  assign alu1_pick = '{vld: a1_found, idx: a1_idx};

  isq_age_pick u_pick_alu2 (
    .cand_i  (alu_cand),
`ifdef ISQ_INT_AGE_SELECT_EN
    .older_i (older_q),
`endif
    .excl_i  (grant_mask(alu1_pick)),
    .found_o (a2_found),
    .idx_o   (a2_idx)
  );

  isq_age_pick u_pick_mul (
    .cand_i  (mul_cand),
`ifdef ISQ_INT_AGE_SELECT_EN
    .older_i (older_q),
`endif
    .excl_i  ('0),
    .found_o (m_found),
    .idx_o   (m_idx)
  );

  assign alu2_pick = '{vld: a2_found, idx: a2_idx};
  assign mul_pick  = '{vld: m_found, idx: m_idx};
  assign pick_m    = grant_mask(alu1_pick) | grant_mask(alu2_pick) | grant_mask(mul_pick);

  always_comb begin
    valid_d   = valid_q;
    ismul_d   = ismul_q;
    alu1_d    = alu1_q;
    alu2_d    = alu2_q;
    mul_d     = mul_q;
    freecnt_d = freecnt_q;
`ifdef ISQ_INT_AGE_SELECT_EN
    older_d   = older_q;
    age_row   = '0;
`endif
    if (isq.IsQuIntFlash) begin
      valid_d   = '0;
      alu1_d    = '0;
      alu2_d    = '0;
      mul_d     = '0;
      freecnt_d = CNT_W'(ENTRY_NUM);
`ifdef ISQ_INT_AGE_SELECT_EN
      older_d   = '0;
`endif
    end else if (!isq.IsQuIntStop) begin
      valid_d = (valid_q & ~pick_m) | alloc_m;
      for (int k = 0; k < DISP_W; k++) begin
        if (ack[k]) ismul_d[slot_idx[k]] = isq.AllocMul[k];
      end
      alu1_d    = alu1_pick;
      alu2_d    = alu2_pick;
      mul_d     = mul_pick;
      freecnt_d = freecnt_q + CNT_W'(alu1_pick.vld) + CNT_W'(alu2_pick.vld)
                + CNT_W'(mul_pick.vld) - count_disp(ack);
`ifdef ISQ_INT_AGE_SELECT_EN
      // Freed columns clear first; a new row sees survivors plus lower-slot siblings as older.
      for (int i = 0; i < ENTRY_NUM; i++) older_d[i] = older_q[i] & ~pick_m;
      for (int k = 0; k < DISP_W; k++) begin
        if (ack[k]) begin
          age_row = valid_q & ~pick_m;
          for (int m = 0; m < k; m++) begin
            if (ack[m]) age_row[slot_idx[m]] = 1'b1;
          end
          older_d[slot_idx[k]] = age_row;
        end
      end
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      valid_q   <= '0;
      ismul_q   <= '0;
      alu1_q    <= '0;
      alu2_q    <= '0;
      mul_q     <= '0;
      freecnt_q <= CNT_W'(ENTRY_NUM);
`ifdef ISQ_INT_AGE_SELECT_EN
      older_q   <= '0;
`endif
    end else begin
      valid_q   <= valid_d;
      ismul_q   <= ismul_d;
      alu1_q    <= alu1_d;
      alu2_q    <= alu2_d;
      mul_q     <= mul_d;
      freecnt_q <= freecnt_d;
`ifdef ISQ_INT_AGE_SELECT_EN
      older_q   <= older_d;
`endif
    end
  end

  assign isq.Alu1Valid = alu1_q.vld;
  assign isq.Alu1Idx   = alu1_q.idx;
  assign isq.Alu2Valid = alu2_q.vld;
  assign isq.Alu2Idx   = alu2_q.idx;
  assign isq.MulValid  = mul_q.vld;
  assign isq.MulIdx    = mul_q.idx;
  assign isq.FreeCnt   = freecnt_q;

endmodule

// File: tb/tb_issue_int_scheduler.sv
// Directed self-checking bench for issue_int_scheduler.
module tb_issue_int_scheduler;

  logic Clk;
  logic Rest;
  int   checks;
  int   errors;

  issue_int_scheduler_if isq();

  issue_int_scheduler dut (
    .Clk  (Clk),
    .Rest (Rest),
    .isq  (isq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic test_reset();
    Rest = 1'b0;
    tick();
    tick();
    Rest = 1'b1;
    #1;
    checks++;
    if (isq.FreeCnt !== 6'd32) begin
      errors++; $display("FAIL reset_freecnt: got %0d expected 32", isq.FreeCnt);
    end
    checks++;
    if (isq.IsQuIntReq !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b expected 0", isq.IsQuIntReq);
    end
    checks++;
    if ({isq.Alu1Valid, isq.Alu2Valid, isq.MulValid} !== 3'b000) begin
      errors++; $display("FAIL reset_grants: got %b expected 000",
                         {isq.Alu1Valid, isq.Alu2Valid, isq.MulValid});
    end
    checks++;
    if (isq.AllocAck !== 4'b0000) begin
      errors++; $display("FAIL reset_ack: got %b expected 0000", isq.AllocAck);
    end
  endtask

  task automatic test_alloc();
    logic [19:0] exp_idx;
    isq.AllocReq = 4'b1111;
    isq.AllocMul = 4'b0000;
    isq.EntryReady = '0;
    #1;
    exp_idx = {5'd3, 5'd2, 5'd1, 5'd0};
    checks++;
    if (isq.AllocIdx !== exp_idx) begin
      errors++; $display("FAIL alloc_idx: got %h expected %h", isq.AllocIdx, exp_idx);
    end
    checks++;
    if (isq.AllocAck !== 4'b1111) begin
      errors++; $display("FAIL alloc_ack: got %b expected 1111", isq.AllocAck);
    end
    tick();
    isq.AllocReq = 4'b0000;
    #1;
    checks++;
    if (isq.FreeCnt !== 6'd28) begin
      errors++; $display("FAIL alloc_freecnt: got %0d expected 28", isq.FreeCnt);
    end
    isq.IsQuIntFlash = 1'b1;
    tick();
    isq.IsQuIntFlash = 1'b0;
    #1;
  endtask

  // Entry 2 becomes the oldest survivor; then 3; then 0,1,4,5 allocated together.
  task automatic test_oldest_first();
    logic [19:0] exp_idx;
    int e1 [3];
    int e2 [3];
`ifdef ISQ_INT_AGE_SELECT_EN
    e1 = '{2, 0, 4}; e2 = '{3, 1, 5};
`else
    e1 = '{0, 2, 4}; e2 = '{1, 3, 5};
`endif
    isq.AllocReq = 4'b0111;
    tick();
    isq.AllocReq = 4'b0000;
    isq.EntryReady = 32'h0000_0003;
    tick();
    isq.EntryReady = '0;
    checks++;
    if (!(isq.Alu1Valid === 1'b1 && isq.Alu1Idx === 5'd0 && isq.Alu2Valid === 1'b1 && isq.Alu2Idx === 5'd1)) begin
      errors++; $display("FAIL first_pair: got %b/%0d %b/%0d expected 1/0 1/1",
                         isq.Alu1Valid, isq.Alu1Idx, isq.Alu2Valid, isq.Alu2Idx);
    end
    // Entries 0 and 1 are on the grant outputs and must be skipped by allocation.
    isq.AllocReq = 4'b0001;
    #1;
    exp_idx = {5'd6, 5'd5, 5'd4, 5'd3};
    checks++;
    if (isq.AllocIdx !== exp_idx) begin
      errors++; $display("FAIL no_same_cycle_reuse: got %h expected %h", isq.AllocIdx, exp_idx);
    end
    tick();
    isq.AllocReq = 4'b1111;
    #1;
    exp_idx = {5'd5, 5'd4, 5'd1, 5'd0};
    checks++;
    if (isq.AllocIdx !== exp_idx) begin
      errors++; $display("FAIL realloc_idx: got %h expected %h", isq.AllocIdx, exp_idx);
    end
    tick();
    isq.AllocReq = 4'b0000;
    isq.EntryReady = '1;
    #1;
    checks++;
    if (isq.FreeCnt !== 6'd26) begin
      errors++; $display("FAIL six_valid_freecnt: got %0d expected 26", isq.FreeCnt);
    end
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (!(isq.Alu1Valid === 1'b1 && isq.Alu1Idx === 5'(e1[s]) && isq.Alu2Valid === 1'b1 &&
            isq.Alu2Idx === 5'(e2[s]) && isq.MulValid === 1'b0)) begin
        errors++; $display("FAIL oldest_pair_%0d: got %b/%0d %b/%0d mul %b expected 1/%0d 1/%0d mul 0",
                           s, isq.Alu1Valid, isq.Alu1Idx, isq.Alu2Valid, isq.Alu2Idx, isq.MulValid,
                           e1[s], e2[s]);
      end
      checks++;
      if (isq.FreeCnt !== 6'(28 + 2 * s)) begin
        errors++; $display("FAIL oldest_freecnt_%0d: got %0d expected %0d", s, isq.FreeCnt, 28 + 2 * s);
      end
    end
    tick();
    isq.EntryReady = '0;
    checks++;
    if ({isq.Alu1Valid, isq.Alu2Valid, isq.MulValid} !== 3'b000) begin
      errors++; $display("FAIL empty_no_grant: got %b expected 000",
                         {isq.Alu1Valid, isq.Alu2Valid, isq.MulValid});
    end
  endtask

  task automatic test_full();
    isq.AllocReq = 4'b1111;
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (!(isq.FreeCnt === 6'd4 && isq.IsQuIntReq === 1'b0)) begin
      errors++; $display("FAIL thresh_edge: got cnt %0d req %b expected cnt 4 req 0",
                         isq.FreeCnt, isq.IsQuIntReq);
    end
    isq.AllocReq = 4'b0001;
    tick();
    isq.AllocReq = 4'b1111;
    #1;
    checks++;
    if (!(isq.FreeCnt === 6'd3 && isq.IsQuIntReq === 1'b1)) begin
      errors++; $display("FAIL full_req: got cnt %0d req %b expected cnt 3 req 1",
                         isq.FreeCnt, isq.IsQuIntReq);
    end
    checks++;
    if (isq.AllocAck !== 4'b0000) begin
      errors++; $display("FAIL full_ack: got %b expected 0000", isq.AllocAck);
    end
    tick();
    checks++;
    if (isq.FreeCnt !== 6'd3) begin
      errors++; $display("FAIL full_hold_cnt: got %0d expected 3", isq.FreeCnt);
    end
    isq.AllocReq = 4'b0000;
    isq.IsQuIntFlash = 1'b1;
    tick();
    isq.IsQuIntFlash = 1'b0;
    checks++;
    if (isq.FreeCnt !== 6'd32) begin
      errors++; $display("FAIL full_flash_cnt: got %0d expected 32", isq.FreeCnt);
    end
  endtask

  task automatic test_mul_and_alu();
    isq.AllocReq = 4'b1111;
    isq.AllocMul = 4'b0000;
    tick();
    isq.AllocMul = 4'b0010;
    tick();
    isq.AllocReq = 4'b0000;
    isq.AllocMul = 4'b0000;
    isq.EntryReady = 32'h0000_00E0;
    #1;
    checks++;
    if (isq.FreeCnt !== 6'd24) begin
      errors++; $display("FAIL mul_setup_cnt: got %0d expected 24", isq.FreeCnt);
    end
    tick();
    checks++;
    if (!(isq.MulValid === 1'b1 && isq.MulIdx === 5'd5 && isq.Alu1Valid === 1'b1 && isq.Alu1Idx === 5'd6 &&
          isq.Alu2Valid === 1'b1 && isq.Alu2Idx === 5'd7)) begin
      errors++; $display("FAIL triple_grant: got mul %b/%0d a1 %b/%0d a2 %b/%0d expected 1/5 1/6 1/7",
                         isq.MulValid, isq.MulIdx, isq.Alu1Valid, isq.Alu1Idx, isq.Alu2Valid, isq.Alu2Idx);
    end
    checks++;
    if (isq.FreeCnt !== 6'd27) begin
      errors++; $display("FAIL triple_cnt: got %0d expected 27", isq.FreeCnt);
    end
    tick();
    checks++;
    if ({isq.Alu1Valid, isq.Alu2Valid, isq.MulValid} !== 3'b000) begin
      errors++; $display("FAIL triple_once: got %b expected 000",
                         {isq.Alu1Valid, isq.Alu2Valid, isq.MulValid});
    end
  endtask

  task automatic test_stop();
    isq.EntryReady = 32'h0000_0003;
    tick();
    isq.IsQuIntStop = 1'b1;
    isq.EntryReady = 32'h0000_001C;
    isq.AllocReq = 4'b1111;
    #1;
    checks++;
    if (isq.AllocAck !== 4'b0000) begin
      errors++; $display("FAIL stop_ack: got %b expected 0000", isq.AllocAck);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (!(isq.Alu1Valid === 1'b1 && isq.Alu1Idx === 5'd0 && isq.Alu2Valid === 1'b1 &&
            isq.Alu2Idx === 5'd1 && isq.MulValid === 1'b0 && isq.FreeCnt === 6'd29 &&
            isq.AllocAck === 4'b0000)) begin
        errors++; $display("FAIL stop_hold_%0d: got a1 %b/%0d a2 %b/%0d mul %b cnt %0d ack %b expected 1/0 1/1 0 29 0000",
                           c, isq.Alu1Valid, isq.Alu1Idx, isq.Alu2Valid, isq.Alu2Idx, isq.MulValid,
                           isq.FreeCnt, isq.AllocAck);
      end
    end
    isq.IsQuIntStop = 1'b0;
    isq.AllocReq = 4'b0000;
    tick();
    checks++;
    if (!(isq.Alu1Idx === 5'd2 && isq.Alu2Idx === 5'd3 && isq.Alu1Valid === 1'b1 &&
          isq.Alu2Valid === 1'b1 && isq.FreeCnt === 6'd31)) begin
      errors++; $display("FAIL stop_release: got a1 %b/%0d a2 %b/%0d cnt %0d expected 1/2 1/3 31",
                         isq.Alu1Valid, isq.Alu1Idx, isq.Alu2Valid, isq.Alu2Idx, isq.FreeCnt);
    end
  endtask

  task automatic test_flash();
    isq.IsQuIntFlash = 1'b1;
    isq.IsQuIntStop = 1'b1;
    isq.AllocReq = 4'b1111;
    isq.EntryReady = '1;
    #1;
    checks++;
    if (isq.AllocAck !== 4'b0000) begin
      errors++; $display("FAIL flash_ack: got %b expected 0000", isq.AllocAck);
    end
    tick();
    isq.IsQuIntFlash = 1'b0;
    isq.IsQuIntStop = 1'b0;
    isq.AllocReq = 4'b0000;
    #1;
    checks++;
    if (!({isq.Alu1Valid, isq.Alu2Valid, isq.MulValid} === 3'b000 && isq.FreeCnt === 6'd32 &&
          isq.IsQuIntReq === 1'b0)) begin
      errors++; $display("FAIL flash_clear: got grants %b cnt %0d req %b expected 000 32 0",
                         {isq.Alu1Valid, isq.Alu2Valid, isq.MulValid}, isq.FreeCnt, isq.IsQuIntReq);
    end
    tick();
    checks++;
    if ({isq.Alu1Valid, isq.Alu2Valid, isq.MulValid} !== 3'b000) begin
      errors++; $display("FAIL flash_no_stale: got %b expected 000",
                         {isq.Alu1Valid, isq.Alu2Valid, isq.MulValid});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rest = 1'b0;
    isq.IsQuIntStop  = 1'b0;
    isq.IsQuIntFlash = 1'b0;
    isq.AllocReq     = '0;
    isq.AllocMul     = '0;
    isq.EntryReady   = '0;
    test_reset();
    test_alloc();
    test_oldest_first();
    test_full();
    test_mul_and_alu();
    test_stop();
    test_flash();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_int_scheduler.md
Name: issue_int_scheduler

Overview:
- Slot-allocation and select controller for the integer issue queue entry array.
- Allocates free entries to up to 4 renamed µops per cycle and drives dispatch backpressure (IsQuIntReq).
- Each cycle, selects up to two ALU µops and one MUL µop for issue, oldest first.
- Tells the queue which entries to write and which to read out and invalidate.

Parameters:
- ENTRY_NUM, 32, number of issue-queue entries.
- IDX_W, 5, entry index width; equals clog2(ENTRY_NUM).
- DISP_W, 4, maximum allocations per cycle.
- REQ_THRESH, 4, free-entry count below which IsQuIntReq asserts.

Ports:
- Clk  in  1  clock.
- Rest  in  1  synchronous reset, active low.
- IsQuIntStop  in  1  hold all state; no alloc, no grant.
- IsQuIntFlash  in  1  flush all entries.
- IsQuIntReq  out  1  stall request to front end.
- AllocReq  in  DISP_W  per-slot allocation request; bit0 = In1 (oldest).
- AllocMul  in  DISP_W  per-slot µop is MUL type.
- AllocIdx  out  DISP_W*IDX_W  entry index per slot; slot k at bits [k*IDX_W +: IDX_W].
- AllocAck  out  DISP_W  per-slot allocation performed this cycle.
- EntryReady  in  ENTRY_NUM  all sources of the entry are woken, from the queue.
- Alu1Valid / Alu1Idx  out  1 / IDX_W  ALU port 1 grant.
- Alu2Valid / Alu2Idx  out  1 / IDX_W  ALU port 2 grant.
- MulValid / MulIdx  out  1 / IDX_W  MUL port grant.
- FreeCnt  out  IDX_W+1  number of free entries.

Behaviour:
- State:
  - Valid[ENTRY_NUM] and IsMul[ENTRY_NUM].
  - Age matrix Older[i][j] = 1 when entry j is older than entry i.
  - FreeCnt register.
  - Registered grant outputs.
- Reset (Rest=0 at a posedge):
  - Valid, IsMul, Older and all grant outputs clear to 0.
  - FreeCnt = ENTRY_NUM; IsQuIntReq = 0; AllocAck = 0.
- IsQuIntReq = (FreeCnt < REQ_THRESH), combinational from the register.
- Allocation (combinational):
  - Enabled only when IsQuIntReq=0, Stop=0 and Flash=0.
  - AllocIdx[k] is the k-th lowest-index free entry.
  - AllocAck[k] = AllocReq[k] & enable.
  - Non-contiguous AllocReq is legal; each requesting slot gets a distinct entry.
  - At the posedge, Valid and IsMul are set for each acked slot.
  - For a new entry i: Older[i][j] = Valid[j] (after this cycle's issue clear) | (j allocated in a lower slot this cycle).
  - Column j clears in every row when entry j is freed.
- Select (combinational from registered state and EntryReady):
  - Cand = Valid & EntryReady & ~issued-last-cycle.
  - ALU1 picks the oldest Cand & ~IsMul entry: the one with no older candidate in its row.
  - ALU2 picks the oldest remaining ALU candidate, excluding the ALU1 pick.
  - MUL picks the oldest Cand & IsMul entry.
- Issue timing:
  - Picks register into the *Valid/*Idx outputs at the posedge (1-cycle latency).
  - The picked entries' Valid clear at that same edge, so no entry is granted twice.
  - A freed entry is allocatable in the cycle after its grant is visible.
- FreeCnt_next = FreeCnt + (#grants issued) − (#allocs); range 0..ENTRY_NUM, never wraps.
- Stop=1:
  - All registers hold, including grant outputs (re-presented).
  - AllocAck = 0.
- Flash=1 (priority over Stop):
  - Next edge clears Valid, Older and grant outputs; FreeCnt = ENTRY_NUM.
  - Allocation in a flash cycle is ignored.
- Simultaneous alloc and issue in one cycle: both are applied. A freed entry is not reused in the same cycle.
- Empty queue: all *Valid = 0. Full queue: AllocAck = 0 and IsQuIntReq = 1.

Optional Feature:
- ISQ_INT_AGE_SELECT_EN defined: oldest-first select via the age matrix, as described above.
- Undefined:
  - Older matrix is not built.
  - ALU1 picks the lowest-index candidate, ALU2 the next lowest, MUL the lowest-index MUL candidate.
  - All other timing is identical.

Decomposition:
- Shared define file holds ENTRY_NUM, IDX_W, DISP_W and REQ_THRESH as `define constants, next to ReNameRegBUs and MicOperateCode.
- One sub-module: isq_age_pick. Inputs are the candidate vector, the Older matrix and an exclude mask. Outputs are found and index. It is instantiated three times (ALU1, ALU2, MUL); with the feature off it reduces to a priority encoder.

Test Plan:
- Reset, then AllocReq=4'b1111, EntryReady=0 → AllocIdx = 0,1,2,3, AllocAck=4'b1111, FreeCnt=28 next cycle.
- Entries 0–3 valid and non-MUL, entry 2 allocated first, EntryReady=all → Alu1Idx=2, Alu2Idx = next oldest, both granted once only.
- Fill to 29 valid → FreeCnt=3, IsQuIntReq=1, AllocAck=0 despite AllocReq=4'b1111.
- MUL entry 5 and ALU entries 6, 7 ready → MulValid=1/MulIdx=5, Alu1Idx=6, Alu2Idx=7 in the same cycle; FreeCnt rises by 3.
- IsQuIntStop=1 for 3 cycles with ready entries → grant outputs frozen, FreeCnt unchanged, AllocAck=0.
- IsQuIntFlash asserted together with Stop and AllocReq → next cycle all *Valid=0, FreeCnt=32, IsQuIntReq=0.
